// File: rtl/seg_disp_pkg.sv
// Shared encodings and helpers for the seven-segment display scheduler.
package seg_disp_pkg;

    typedef enum logic [1:0] {
        GS_IDLE  = 2'd0,
        GS_PLAY  = 2'd1,
        GS_PAUSE = 2'd2,
        GS_OVER  = 2'd3
    } game_state_t;

    localparam logic [5:0] PT_NONE = 6'b000000;
    localparam logic [5:0] PT_HI   = 6'b000001;
    localparam logic [5:0] PT_SEP  = 6'b010000;

    localparam logic [15:0] DATA_MAX = 16'd9999;
    localparam logic [7:0]  BCD_MAX  = 8'd99;

    // Everything the driver sees, bundled so it can be registered in one place.
    typedef struct packed {
        logic [15:0] data;
        logic [7:0]  bcd_data;
        logic [5:0]  point;
        logic        seg_en;
        logic        sign;
    } disp_out_t;

    // Clamp a binary value to what four digits can show.
    function automatic logic [15:0] sat_data(input logic [15:0] v);
        return (v > DATA_MAX) ? DATA_MAX : v;
    endfunction

    // Clamp a binary value to what two digits can show.
    function automatic logic [7:0] sat_bcd(input logic [7:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/seg_disp_sched_ms_tick.sv
// Free-running millisecond prescaler; tick is high for the terminal count cycle.
module ms_tick #(
    parameter int CLK_PER_MS = 50_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    output logic tick
);

    localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
    localparam logic [CW-1:0] TERM = CW'(CLK_PER_MS - 1);

    logic [CW-1:0] cnt_reg;

    // Count 0..CLK_PER_MS-1 forever; only reset clears it.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            cnt_reg <= '0;
        else if (cnt_reg == TERM)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign tick = (cnt_reg == TERM);

endmodule

// File: rtl/seg_disp_sched.sv
// Chooses what the six-digit display shows from game state, paging timers and
// the transient event overlay. All driver outputs are registered.
module seg_disp_sched
    import seg_disp_pkg::*;
#(
    parameter int CLK_PER_MS = 50_000,
    parameter int ROT_MS     = 2000,
    parameter int BLINK_MS   = 500,
    parameter int EVT_MS     = 1000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [1:0]  game_state,
    input  logic [15:0] score,
    input  logic [15:0] hi_score,
    input  logic [7:0]  level,
    input  logic        evt_req,
    input  logic [15:0] evt_data,
    input  logic        evt_neg,
    output logic [15:0] data,
    output logic [7:0]  bcd_data,
    output logic [5:0]  point,
    output logic        seg_en,
    output logic        sign,
    output logic        evt_busy
);

    localparam logic [15:0] ROT_TERM   = 16'(ROT_MS - 1);
    localparam logic [15:0] BLINK_TERM = 16'(BLINK_MS - 1);
    localparam logic [15:0] EVT_TERM   = 16'(EVT_MS - 1);

    logic        tick;
    game_state_t gs;

    game_state_t mode_reg;
    logic [15:0] ms_cnt_reg, ms_cnt_next;
    logic        page_reg, page_next;
    logic        busy_reg, busy_next;
    logic [15:0] evt_cnt_reg, evt_cnt_next;
    logic [15:0] evt_val_reg, evt_val_next;
    logic        evt_neg_reg, evt_neg_next;
    disp_out_t   out_reg, out_next;

    ms_tick #(.CLK_PER_MS(CLK_PER_MS)) u_ms_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .tick      (tick)
    );

    assign gs = game_state_t'(game_state);

    // State register: mode copy, paging and overlay counters, output register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            mode_reg    <= GS_IDLE;
            ms_cnt_reg  <= '0;
            page_reg    <= 1'b0;
            busy_reg    <= 1'b0;
            evt_cnt_reg <= '0;
            evt_val_reg <= '0;
            evt_neg_reg <= 1'b0;
            out_reg     <= '0;
        end else begin
            mode_reg    <= gs;
            ms_cnt_reg  <= ms_cnt_next;
            page_reg    <= page_next;
            busy_reg    <= busy_next;
            evt_cnt_reg <= evt_cnt_next;
            evt_val_reg <= evt_val_next;
            evt_neg_reg <= evt_neg_next;
            out_reg     <= out_next;
        end
    end

    // Next state: page timer restarts on any mode change; overlay runs independently.
    always_comb begin
        logic        paging;
        logic [15:0] term;
        paging       = 1'b0;
        term         = ROT_TERM;
        ms_cnt_next  = ms_cnt_reg;
        page_next    = page_reg;
        busy_next    = busy_reg;
        evt_cnt_next = evt_cnt_reg;
        evt_val_next = evt_val_reg;
        evt_neg_next = evt_neg_reg;

        case (mode_reg)
            GS_IDLE: begin paging = 1'b1; term = ROT_TERM;   end
            GS_OVER: begin paging = 1'b1; term = BLINK_TERM; end
            default: begin paging = 1'b0; term = ROT_TERM;   end
        endcase

        if (gs != mode_reg) begin
            ms_cnt_next = '0;
            page_next   = 1'b0;
        end else if (paging && tick) begin
            if (ms_cnt_reg == term) begin
                ms_cnt_next = '0;
                page_next   = ~page_reg;
            end else begin
                ms_cnt_next = ms_cnt_reg + 16'd1;
            end
        end

        // A new request always wins over the running count (retrigger).
        if (evt_req) begin
            busy_next    = 1'b1;
            evt_cnt_next = '0;
            evt_val_next = evt_data;
            evt_neg_next = evt_neg;
        end else if (busy_reg && tick) begin
            if (evt_cnt_reg == EVT_TERM) begin
                busy_next    = 1'b0;
                evt_cnt_next = '0;
            end else begin
                evt_cnt_next = evt_cnt_reg + 16'd1;
            end
        end
    end

    // Output selection from the next-state view so outputs lag inputs by one cycle.
    always_comb begin
        out_next = '0;
        if (busy_next) begin
            out_next.data   = sat_data(evt_val_next);
            out_next.sign   = evt_neg_next;
            out_next.seg_en = 1'b1;
        end else begin
            case (gs)
                GS_IDLE: begin
                    out_next.data   = page_next ? sat_data(hi_score) : sat_data(score);
                    out_next.point  = page_next ? PT_HI : PT_NONE;
                    out_next.seg_en = 1'b1;
                end
                GS_PLAY, GS_PAUSE: begin
                    out_next.data     = sat_data(score);
                    out_next.bcd_data = sat_bcd(level);
                    out_next.point    = PT_SEP;
                    out_next.seg_en   = (gs == GS_PLAY);
                end
                default: begin
                    out_next.data   = page_next ? sat_data(hi_score) : sat_data(score);
                    out_next.point  = page_next ? PT_HI : PT_NONE;
                    out_next.sign   = ~page_next;
                    out_next.seg_en = 1'b1;
                end
            endcase
        end
    end

    assign data     = out_reg.data;
    assign bcd_data = out_reg.bcd_data;
    assign point    = out_reg.point;
    assign seg_en   = out_reg.seg_en;
    assign sign     = out_reg.sign;
    assign evt_busy = busy_reg;

endmodule
